// File: rtl/led_phase_scheduler.sv
// Alternating RED/IR LED phase scheduler: settles the AFE, averages ADC samples per phase
// and publishes per-colour results; new settings are latched only at a frame boundary.
module led_phase_scheduler #(
  parameter int unsigned SETTLE_CYC  = 3,
  parameter int unsigned SAMPLE_LOG2 = 2
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       cfg_load,
  input  logic [6:0] cfg_red_dc,
  input  logic [3:0] cfg_red_pga,
  input  logic [6:0] cfg_ir_dc,
  input  logic [3:0] cfg_ir_pga,
  input  logic [7:0] ADC,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic [7:0] RED_ADC_Value,
  output logic [7:0] IR_ADC_Value,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RED_SETTLE = 3'd1;
  localparam logic [2:0] ST_RED_SAMPLE = 3'd2;
  localparam logic [2:0] ST_IR_SETTLE  = 3'd3;
  localparam logic [2:0] ST_IR_SAMPLE  = 3'd4;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] SAMPLE_LAST = 4'((1 << SAMPLE_LOG2) - 1);

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [11:0] r_acc;
  logic [6:0]  r_sh_red_dc, r_sh_ir_dc, r_wk_red_dc, r_wk_ir_dc;
  logic [3:0]  r_sh_red_pga, r_sh_ir_pga, r_wk_red_pga, r_wk_ir_pga;
  logic        r_led_red, r_led_ir, r_frame_done, r_busy;
  logic [6:0]  r_dc;
  logic [3:0]  r_pga;
  logic [7:0]  r_red_val, r_ir_val;

  logic [2:0]  w_state_d;
  logic [3:0]  w_cnt_d;
  logic [11:0] w_acc_d, w_sum;
  logic [7:0]  w_avg;
  logic        w_settle_last, w_sample_last, w_start, w_red_wr, w_ir_wr;
  logic [6:0]  w_sh_red_dc, w_sh_ir_dc, w_wk_red_dc, w_wk_ir_dc, w_dc_d;
  logic [3:0]  w_sh_red_pga, w_sh_ir_pga, w_wk_red_pga, w_wk_ir_pga, w_pga_d;
  logic        w_led_red_d, w_led_ir_d;

  // Shadow values seen this cycle include a same-cycle cfg_load, so a load coinciding
  // with frame entry is used by that frame.
  always_comb begin
    w_sh_red_dc  = cfg_load ? cfg_red_dc  : r_sh_red_dc;
    w_sh_red_pga = cfg_load ? cfg_red_pga : r_sh_red_pga;
    w_sh_ir_dc   = cfg_load ? cfg_ir_dc   : r_sh_ir_dc;
    w_sh_ir_pga  = cfg_load ? cfg_ir_pga  : r_sh_ir_pga;
  end

  always_comb begin
    w_sum         = r_acc + {4'd0, ADC};
    w_avg         = 8'(w_sum >> SAMPLE_LOG2);
    w_settle_last = (r_cnt == SETTLE_LAST);
    w_sample_last = (r_cnt == SAMPLE_LAST);
    w_state_d     = r_state;
    w_cnt_d       = r_cnt + 4'd1;
    w_acc_d       = r_acc;
    w_start       = 1'b0;
    w_red_wr      = 1'b0;
    w_ir_wr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_d = 4'd0;
        if (enable) begin
          w_state_d = ST_RED_SETTLE;
          w_start   = 1'b1;
        end
      end
      ST_RED_SETTLE: begin
        if (w_settle_last) begin
          w_state_d = ST_RED_SAMPLE;
          w_cnt_d   = 4'd0;
          w_acc_d   = 12'd0;
        end
      end
      ST_RED_SAMPLE: begin
        w_acc_d = w_sum;
        if (w_sample_last) begin
          w_state_d = ST_IR_SETTLE;
          w_cnt_d   = 4'd0;
          w_red_wr  = 1'b1;
        end
      end
      ST_IR_SETTLE: begin
        if (w_settle_last) begin
          w_state_d = ST_IR_SAMPLE;
          w_cnt_d   = 4'd0;
          w_acc_d   = 12'd0;
        end
      end
      ST_IR_SAMPLE: begin
        w_acc_d = w_sum;
        if (w_sample_last) begin
          w_cnt_d = 4'd0;
          w_ir_wr = 1'b1;
          if (enable) begin
            w_state_d = ST_RED_SETTLE;
            w_start   = 1'b1;
          end else begin
            w_state_d = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_d = ST_IDLE;
        w_cnt_d   = 4'd0;
        w_acc_d   = 12'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    w_wk_red_dc  = w_start ? w_sh_red_dc  : r_wk_red_dc;
    w_wk_red_pga = w_start ? w_sh_red_pga : r_wk_red_pga;
    w_wk_ir_dc   = w_start ? w_sh_ir_dc   : r_wk_ir_dc;
    w_wk_ir_pga  = w_start ? w_sh_ir_pga  : r_wk_ir_pga;
    w_led_red_d  = (w_state_d == ST_RED_SETTLE) || (w_state_d == ST_RED_SAMPLE);
    w_led_ir_d   = (w_state_d == ST_IR_SETTLE) || (w_state_d == ST_IR_SAMPLE);
    w_dc_d       = 7'd0;
    w_pga_d      = 4'd0;
    if (w_led_red_d) begin
      w_dc_d  = w_wk_red_dc;
      w_pga_d = w_wk_red_pga;
    end else if (w_led_ir_d) begin
      w_dc_d  = w_wk_ir_dc;
      w_pga_d = w_wk_ir_pga;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_acc        <= 12'd0;
      r_sh_red_dc  <= 7'd0;
      r_sh_red_pga <= 4'd0;
      r_sh_ir_dc   <= 7'd0;
      r_sh_ir_pga  <= 4'd0;
      r_wk_red_dc  <= 7'd0;
      r_wk_red_pga <= 4'd0;
      r_wk_ir_dc   <= 7'd0;
      r_wk_ir_pga  <= 4'd0;
      r_led_red    <= 1'b0;
      r_led_ir     <= 1'b0;
      r_dc         <= 7'd0;
      r_pga        <= 4'd0;
      r_red_val    <= 8'd0;
      r_ir_val     <= 8'd0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_acc        <= w_acc_d;
      r_sh_red_dc  <= w_sh_red_dc;
      r_sh_red_pga <= w_sh_red_pga;
      r_sh_ir_dc   <= w_sh_ir_dc;
      r_sh_ir_pga  <= w_sh_ir_pga;
      r_wk_red_dc  <= w_wk_red_dc;
      r_wk_red_pga <= w_wk_red_pga;
      r_wk_ir_dc   <= w_wk_ir_dc;
      r_wk_ir_pga  <= w_wk_ir_pga;
      r_led_red    <= w_led_red_d;
      r_led_ir     <= w_led_ir_d;
      r_dc         <= w_dc_d;
      r_pga        <= w_pga_d;
      r_frame_done <= w_ir_wr;
      r_busy       <= (w_state_d != ST_IDLE);
      if (w_red_wr) r_red_val <= w_avg;
      if (w_ir_wr)  r_ir_val  <= w_avg;
    end
  end

  assign LED_RED       = r_led_red;
  assign LED_IR        = r_led_ir;
  assign DC_Comp       = r_dc;
  assign PGA_Gain      = r_pga;
  assign RED_ADC_Value = r_red_val;
  assign IR_ADC_Value  = r_ir_val;
  assign frame_done    = r_frame_done;
  assign busy          = r_busy;

endmodule

// File: tb/tb_led_phase_scheduler.sv
// Bench for led_phase_scheduler: default instance plus a SAMPLE_LOG2=4 instance on shared
// stimulus, both checked every cycle against a frame-position reference model.
module tb_led_phase_scheduler;

  localparam int SET = 3;

  logic       CLK = 1'b0;
  logic       rst_n, enable, cfg_load;
  logic [6:0] cfg_red_dc, cfg_ir_dc;
  logic [3:0] cfg_red_pga, cfg_ir_pga;
  logic [7:0] ADC;

  logic [1:0]      d_led_red, d_led_ir, d_fd, d_busy;
  logic [1:0][6:0] d_dc;
  logic [1:0][3:0] d_pga;
  logic [1:0][7:0] d_red, d_ir;

  int n_checks = 0;
  int n_err    = 0;

  always #5 CLK = ~CLK;

  led_phase_scheduler dut0 (
    .CLK(CLK), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load),
    .cfg_red_dc(cfg_red_dc), .cfg_red_pga(cfg_red_pga),
    .cfg_ir_dc(cfg_ir_dc), .cfg_ir_pga(cfg_ir_pga), .ADC(ADC),
    .LED_RED(d_led_red[0]), .LED_IR(d_led_ir[0]), .DC_Comp(d_dc[0]), .PGA_Gain(d_pga[0]),
    .RED_ADC_Value(d_red[0]), .IR_ADC_Value(d_ir[0]), .frame_done(d_fd[0]), .busy(d_busy[0])
  );

  led_phase_scheduler #(.SETTLE_CYC(3), .SAMPLE_LOG2(4)) dut1 (
    .CLK(CLK), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load),
    .cfg_red_dc(cfg_red_dc), .cfg_red_pga(cfg_red_pga),
    .cfg_ir_dc(cfg_ir_dc), .cfg_ir_pga(cfg_ir_pga), .ADC(ADC),
    .LED_RED(d_led_red[1]), .LED_IR(d_led_ir[1]), .DC_Comp(d_dc[1]), .PGA_Gain(d_pga[1]),
    .RED_ADC_Value(d_red[1]), .IR_ADC_Value(d_ir[1]), .frame_done(d_fd[1]), .busy(d_busy[1])
  );

  // Model: position within the frame; red half is [0, SET+n), ir half is the rest.
  typedef struct packed {
    logic        act;
    logic [7:0]  pos;
    logic [15:0] sum;
    logic [7:0]  red;
    logic [7:0]  ir;
    logic        fd;
    logic [6:0]  wrdc;
    logic [6:0]  widc;
    logic [3:0]  wrpga;
    logic [3:0]  wipga;
  } mst_t;

  mst_t       m [2];
  logic [6:0] m_sh_rdc, m_sh_idc;
  logic [3:0] m_sh_rpga, m_sh_ipga;

  function automatic int n_of(input int i);
    return (i == 0) ? 4 : 16;
  endfunction

  function automatic int l_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic mst_t step(input mst_t s, input int i, input logic en, input logic [7:0] adc,
                                input logic [6:0] rdc, input logic [3:0] rpga,
                                input logic [6:0] idc, input logic [3:0] ipga);
    mst_t r   = s;
    int   n   = n_of(i);
    int   l   = l_of(i);
    int   f   = 2 * (SET + n);
    int   pos = int'(s.pos);
    int   sum = int'(s.sum);
    r.fd = 1'b0;
    if (!s.act) begin
      if (en) begin
        r.act = 1'b1; r.pos = 8'd0;
        r.wrdc = rdc; r.wrpga = rpga; r.widc = idc; r.wipga = ipga;
      end
    end else begin
      if (pos == SET || pos == 2 * SET + n) sum = int'(adc);
      else if ((pos > SET && pos < SET + n) || pos > 2 * SET + n) sum = sum + int'(adc);
      if (pos == SET + n - 1) r.red = 8'(sum >> l);
      if (pos == f - 1) begin
        r.ir = 8'(sum >> l);
        r.fd = 1'b1;
        r.pos = 8'd0;
        if (en) begin
          r.wrdc = rdc; r.wrpga = rpga; r.widc = idc; r.wipga = ipga;
        end else begin
          r.act = 1'b0;
        end
      end else begin
        r.pos = 8'(pos + 1);
      end
      r.sum = 16'(sum);
    end
    return r;
  endfunction

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      m_sh_rdc <= '0; m_sh_idc <= '0; m_sh_rpga <= '0; m_sh_ipga <= '0;
      for (int i = 0; i < 2; i++) m[i] <= '0;
    end else begin
      m_sh_rdc  <= cfg_load ? cfg_red_dc  : m_sh_rdc;
      m_sh_rpga <= cfg_load ? cfg_red_pga : m_sh_rpga;
      m_sh_idc  <= cfg_load ? cfg_ir_dc   : m_sh_idc;
      m_sh_ipga <= cfg_load ? cfg_ir_pga  : m_sh_ipga;
      for (int i = 0; i < 2; i++)
        m[i] <= step(m[i], i, enable, ADC,
                     cfg_load ? cfg_red_dc : m_sh_rdc, cfg_load ? cfg_red_pga : m_sh_rpga,
                     cfg_load ? cfg_ir_dc : m_sh_idc, cfg_load ? cfg_ir_pga : m_sh_ipga);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic       e_red, e_ir;
      logic [6:0] e_dc;
      logic [3:0] e_pga;
      e_red = m[i].act && (int'(m[i].pos) < SET + n_of(i));
      e_ir  = m[i].act && (int'(m[i].pos) >= SET + n_of(i));
      e_dc  = e_red ? m[i].wrdc : (e_ir ? m[i].widc : 7'd0);
      e_pga = e_red ? m[i].wrpga : (e_ir ? m[i].wipga : 4'd0);
      chk($sformatf("%s.led_red[%0d]", tag, i), 16'(d_led_red[i]), 16'(e_red));
      chk($sformatf("%s.led_ir[%0d]", tag, i), 16'(d_led_ir[i]), 16'(e_ir));
      chk($sformatf("%s.dc[%0d]", tag, i), 16'(d_dc[i]), 16'(e_dc));
      chk($sformatf("%s.pga[%0d]", tag, i), 16'(d_pga[i]), 16'(e_pga));
      chk($sformatf("%s.red_val[%0d]", tag, i), 16'(d_red[i]), 16'(m[i].red));
      chk($sformatf("%s.ir_val[%0d]", tag, i), 16'(d_ir[i]), 16'(m[i].ir));
      chk($sformatf("%s.frame_done[%0d]", tag, i), 16'(d_fd[i]), 16'(m[i].fd));
      chk($sformatf("%s.busy[%0d]", tag, i), 16'(d_busy[i]), 16'(m[i].act));
    end
  endtask

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++)
      chk($sformatf("led_excl[%0d]", i), 16'(d_led_red[i] & d_led_ir[i]), 16'd0);
  end

  task automatic cyc(input string tag);
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic wait_pos(input int target);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (m[0].act && int'(m[0].pos) == target) begin
        hit = 1'b1;
        break;
      end
      cyc("run");
    end
    if (!hit) begin
      n_checks++;
      n_err++;
      $error("FAIL sync_timeout observed=none expected=pos%0d", target);
    end
  endtask

  initial begin
    bit seen_fd;
    rst_n = 1'b0; enable = 1'b0; cfg_load = 1'b0; ADC = 8'd0;
    cfg_red_dc = 7'd0; cfg_red_pga = 4'd0; cfg_ir_dc = 7'd0; cfg_ir_pga = 4'd0;
    cyc("reset");
    cyc("reset");
    chk("reset_busy", 16'(d_busy[0]), 16'd0);
    chk("reset_dc", 16'(d_dc[0]), 16'd0);

    // Basic frame, config loaded in the same cycle as frame entry.
    rst_n = 1'b1;
    cfg_load = 1'b1; cfg_red_dc = 7'd40; cfg_red_pga = 4'd5; cfg_ir_dc = 7'd90; cfg_ir_pga = 4'd3;
    enable = 1'b1; ADC = 8'd100;
    cyc("basic");
    cfg_load = 1'b0;
    chk("basic_first_red", 16'(d_led_red[0]), 16'd1);
    chk("basic_first_dc", 16'(d_dc[0]), 16'd40);
    repeat (27) cyc("basic");
    chk("basic_red_val", 16'(d_red[0]), 16'd100);
    chk("basic_ir_val", 16'(d_ir[0]), 16'd100);

    // Averaging truncation: 10+11+11+11 = 43, >>2 = 10.
    wait_pos(SET);
    ADC = 8'd10;
    cyc("avg");
    ADC = 8'd11;
    repeat (3) cyc("avg");
    chk("avg_trunc", 16'(d_red[0]), 16'd10);

    // Config change during IR_SAMPLE only lands at the next frame.
    wait_pos(2 * SET + 4);
    cfg_load = 1'b1; cfg_red_dc = 7'd60;
    cyc("cfg");
    cfg_load = 1'b0;
    chk("cfg_hold_a", 16'(d_dc[0]), 16'd90);
    cyc("cfg");
    chk("cfg_hold_b", 16'(d_dc[0]), 16'd90);
    cyc("cfg");
    chk("cfg_hold_c", 16'(d_dc[0]), 16'd90);
    cyc("cfg");
    chk("cfg_new_dc", 16'(d_dc[0]), 16'd60);
    chk("cfg_pga", 16'(d_pga[0]), 16'd5);

    // Enable drop mid-frame completes the frame then idles.
    wait_pos(SET + 1);
    enable = 1'b0;
    seen_fd = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc("drop");
      if (d_fd[0] === 1'b1) seen_fd = 1'b1;
      if (!m[0].act) break;
    end
    chk("drop_fd_seen", 16'(seen_fd), 16'd1);
    chk("drop_busy", 16'(d_busy[0]), 16'd0);
    chk("drop_leds", 16'({d_led_red[0], d_led_ir[0]}), 16'd0);
    repeat (40) cyc("idle");

    // Asynchronous reset in IR_SETTLE.
    enable = 1'b1;
    wait_pos(SET + 5);
    #2 rst_n = 1'b0;
    #1 check_all("rst_async");
    chk("rst_async_ir_led", 16'(d_led_ir[0]), 16'd0);
    chk("rst_async_red_val", 16'(d_red[0]), 16'd0);
    cyc("rst_hold");
    chk("rst_no_fd", 16'(d_fd[0]), 16'd0);
    rst_n = 1'b1;
    cyc("restart");
    chk("restart_red", 16'(d_led_red[0]), 16'd1);
    chk("restart_busy", 16'(d_busy[0]), 16'd1);
    repeat (13) cyc("restart");

    // Extremes: full-scale input on both instances.
    ADC = 8'd255;
    repeat (80) cyc("full");
    chk("full_red16", 16'(d_red[1]), 16'd255);
    chk("full_ir16", 16'(d_ir[1]), 16'd255);
    chk("full_red4", 16'(d_red[0]), 16'd255);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      ADC      = 8'($urandom);
      enable   = ($urandom_range(0, 15) != 0);
      cfg_load = ($urandom_range(0, 7) == 0);
      cfg_red_dc  = 7'($urandom); cfg_red_pga = 4'($urandom);
      cfg_ir_dc   = 7'($urandom); cfg_ir_pga  = 4'($urandom);
      cyc("rand");
    end
    enable = 1'b0; cfg_load = 1'b0;
    repeat (50) cyc("drain");
    chk("drain_busy", 16'(d_busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
